// File: rtl/siteswap_pattern_entry.sv
// Beat-driven siteswap entry: captures throws, validates landing slots, divides out the ball count,
// commits only valid patterns and drives a multiplexed seven-segment display.
module siteswap_pattern_entry #(
  parameter int MAX_LEN        = 7,
  parameter int THROW_W        = 4,
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 100000,
  parameter int LEN_W          = $clog2(MAX_LEN + 1),
  parameter int BALL_W         = THROW_W
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              new_beat,
  input  logic                              undo_in,
  input  logic [THROW_W-1:0]                throw_in,
  input  logic [LEN_W-1:0]                  pattern_length,
  output logic [MAX_LEN-1:0][THROW_W-1:0]   pattern_out,
  output logic [LEN_W-1:0]                  length_out,
  output logic [BALL_W-1:0]                 num_balls_out,
  output logic                              pattern_valid_out,
  output logic                              pattern_load_out,
  output logic                              error_out,
  output logic [6:0]                        cat_out,
  output logic [NUM_DIGITS-1:0]             an_out
);

  localparam int SUM_W  = $clog2(MAX_LEN * ((1 << THROW_W) - 1) + 1);
  localparam int SLOT_W = ((LEN_W > THROW_W) ? LEN_W : THROW_W) + 1;
  localparam int RC_W   = $clog2(REFRESH_CYCLES + 1);
  localparam int DSEL_W = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {S_INPUT, S_CHECK, S_DIVIDE, S_RESULT} state_t;

  state_t                           state;
  logic [MAX_LEN-1:0][THROW_W-1:0]  pat_buf;
  logic [MAX_LEN-1:0][THROW_W-1:0]  buf_masked;
  logic [LEN_W-1:0]                 index;
  logic [LEN_W-1:0]                 len;
  logic [LEN_W-1:0]                 k;
  logic [MAX_LEN-1:0]               mask;
  logic [MAX_LEN-1:0]               mask_next;
  logic [SUM_W-1:0]                 sum;
  logic [SUM_W-1:0]                 sum_next;
  logic [SUM_W-1:0]                 rem;
  logic [SUM_W-1:0]                 len_sum;
  logic [BALL_W-1:0]                q;
  logic                             res_ok;
  logic [RC_W-1:0]                  refresh_cnt;
  logic [NUM_DIGITS-1:0]            an_sel;

  logic [LEN_W-1:0]                 cur_len;
  logic                             len_ok;
  logic [THROW_W-1:0]               k_throw;
  logic [SLOT_W-1:0]                k_plus;
  logic [SLOT_W-1:0]                slot_full;
  logic                             collide;

  // Until the first beat latches len, the live length input governs acceptance.
  assign cur_len  = (index == '0) ? pattern_length : len;
  assign len_ok   = (cur_len != '0) && (cur_len <= LEN_W'(MAX_LEN));
  assign k_throw  = pat_buf[k];
  assign k_plus   = SLOT_W'(k) + SLOT_W'(k_throw);
  assign slot_full = (len == '0) ? '0 : (k_plus % SLOT_W'(len));
  assign sum_next = sum + SUM_W'(k_throw);
  assign len_sum  = SUM_W'(len);

  always_comb begin
    collide   = 1'b0;
    mask_next = mask;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (slot_full == SLOT_W'(i)) begin
        collide      = mask[i];
        mask_next[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++)
      buf_masked[i] = (LEN_W'(i) < len) ? pat_buf[i] : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= S_INPUT;
      pat_buf           <= '0;
      index             <= '0;
      len               <= '0;
      k                 <= '0;
      mask              <= '0;
      sum               <= '0;
      rem               <= '0;
      q                 <= '0;
      res_ok            <= 1'b0;
      pattern_out       <= '0;
      length_out        <= '0;
      num_balls_out     <= '0;
      pattern_valid_out <= 1'b0;
      pattern_load_out  <= 1'b0;
      error_out         <= 1'b0;
      refresh_cnt       <= '0;
      an_sel            <= NUM_DIGITS'(1);
    end else begin
      pattern_load_out <= 1'b0;
      error_out        <= 1'b0;

      if (refresh_cnt == RC_W'(REFRESH_CYCLES - 1)) begin
        refresh_cnt <= '0;
        an_sel      <= {an_sel[NUM_DIGITS-2:0], an_sel[NUM_DIGITS-1]};
      end else begin
        refresh_cnt <= refresh_cnt + RC_W'(1);
      end

      case (state)
        S_INPUT: begin
          // Undo takes priority; a coincident beat is dropped.
          if (undo_in) begin
            if (index != '0) begin
              index                        <= index - LEN_W'(1);
              pat_buf[index - LEN_W'(1)]   <= '0;
            end
          end else if (new_beat && len_ok) begin
            if (index == '0) len <= pattern_length;
            pat_buf[index] <= throw_in;
            index          <= index + LEN_W'(1);
            if (index + LEN_W'(1) == cur_len) begin
              state <= S_CHECK;
              k     <= '0;
              mask  <= '0;
              sum   <= '0;
            end
          end
        end
        S_CHECK: begin
          if (collide) begin
            state     <= S_RESULT;
            res_ok    <= 1'b0;
            error_out <= 1'b1;
          end else begin
            mask <= mask_next;
            sum  <= sum_next;
            k    <= k + LEN_W'(1);
            if (k == len - LEN_W'(1)) begin
              state <= S_DIVIDE;
              rem   <= sum_next;
              q     <= '0;
            end
          end
        end
        S_DIVIDE: begin
          if (rem >= len_sum) begin
            rem <= rem - len_sum;
            q   <= q + BALL_W'(1);
          end else begin
            state             <= S_RESULT;
            res_ok            <= 1'b1;
            pattern_out       <= buf_masked;
            length_out        <= len;
            num_balls_out     <= q;
            pattern_valid_out <= 1'b1;
            pattern_load_out  <= 1'b1;
          end
        end
        S_RESULT: begin
          if (new_beat) begin
            pat_buf <= '0;
            index   <= '0;
            state   <= S_INPUT;
          end
        end
      endcase
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  logic [DSEL_W-1:0]  sel_idx;
  int                 entry_d;
  logic [THROW_W-1:0] disp_throw;
  logic [6:0]         seg;

  always_comb begin
    sel_idx = '0;
    for (int a = 0; a < NUM_DIGITS; a++)
      if (an_sel[a]) sel_idx = DSEL_W'(a);
  end

  // Leftmost anode shows entry 0.
  assign entry_d = NUM_DIGITS - 1 - int'(sel_idx);

  always_comb begin
    disp_throw = '0;
    for (int j = 0; j < MAX_LEN; j++)
      if (j == entry_d) disp_throw = pat_buf[j];
  end

  always_comb begin
    seg = 7'b0000000;
    case (state)
      S_INPUT: begin
        if (entry_d < int'(index))
          seg = hex7(4'(disp_throw));
        else if (entry_d == int'(index) && index < cur_len)
          seg = hex7(4'(throw_in));
      end
      S_CHECK, S_DIVIDE: begin
        if (entry_d < int'(len)) seg = hex7(4'(disp_throw));
      end
      S_RESULT: begin
        if (res_ok) begin
          if (sel_idx == '0)
            seg = hex7(4'(num_balls_out));
          else if (entry_d < int'(len))
            seg = hex7(4'(disp_throw));
        end else begin
          if (sel_idx == DSEL_W'(2))
            seg = 7'b1111001;
          else if (sel_idx < DSEL_W'(2))
            seg = 7'b1010000;
        end
      end
    endcase
  end

  assign cat_out = ~seg;
  assign an_out  = ~an_sel;

endmodule

// File: tb/tb_siteswap_pattern_entry.sv
// Randomised and directed bench for siteswap_pattern_entry against a siteswap reference model.
module tb_siteswap_pattern_entry;
  localparam int ML = 7, TW = 4, ND = 8, RC = 3, LW = 3, BW = 4;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                   rst_in, new_beat, undo_in;
  logic [TW-1:0]          throw_in;
  logic [LW-1:0]          pattern_length;
  logic [ML-1:0][TW-1:0]  pattern_out;
  logic [LW-1:0]          length_out;
  logic [BW-1:0]          num_balls_out;
  logic                   pattern_valid_out, pattern_load_out, error_out;
  logic [6:0]             cat_out;
  logic [ND-1:0]          an_out;

  siteswap_pattern_entry #(.MAX_LEN(ML), .THROW_W(TW), .NUM_DIGITS(ND), .REFRESH_CYCLES(RC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_beat(new_beat), .undo_in(undo_in),
    .throw_in(throw_in), .pattern_length(pattern_length), .pattern_out(pattern_out),
    .length_out(length_out), .num_balls_out(num_balls_out), .pattern_valid_out(pattern_valid_out),
    .pattern_load_out(pattern_load_out), .error_out(error_out), .cat_out(cat_out), .an_out(an_out));

  int ticks = 0;
  always @(posedge clk_in) if (rst_in) ticks <= 0; else ticks <= ticks + 1;

  int errors = 0, checks = 0;
  int m_buf[ML];
  int m_idx = 0, m_len = 0;
  int c_pat[ML];
  int c_len = 0, c_balls = 0;
  bit c_valid = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hexseg(input int v);
    case (v & 15)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // mode 0: entering, 1: valid result, 2: error result
  function automatic logic [6:0] exp_cat(input int mode, input int an);
    logic [6:0] s;
    int d, bound;
    s = 7'h00;
    d = ND - 1 - an;
    if (mode == 0) begin
      bound = (m_idx == 0) ? int'(pattern_length) : m_len;
      if (d < m_idx) s = hexseg(m_buf[d]);
      else if (d == m_idx && m_idx < bound) s = hexseg(int'(throw_in));
    end else if (mode == 1) begin
      if (an == 0) s = hexseg(c_balls);
      else if (d < c_len) s = hexseg(c_pat[d]);
    end else begin
      if (an == 2) s = 7'b1111001;
      else if (an < 2) s = 7'b1010000;
    end
    return ~s;
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic disp_chk(input int mode);
    int an;
    logic [ND-1:0] ea;
    an = (ticks / RC) % ND;
    ea = ~(ND'(1) << an);
    chk("anode", an_out, ea);
    chk("cathode", cat_out, exp_cat(mode, an));
  endtask

  task automatic beat_in(input int v);
    throw_in = TW'(v); new_beat = 1; tick(); new_beat = 0;
    if (m_idx == 0) m_len = int'(pattern_length);
    if (m_len >= 1 && m_len <= ML) begin
      m_buf[m_idx] = v;
      m_idx++;
    end
  endtask

  task automatic undo(input bit with_beat, input int v);
    throw_in = TW'(v); undo_in = 1; new_beat = with_beat; tick();
    undo_in = 0; new_beat = 0;
    if (m_idx > 0) begin
      m_idx--;
      m_buf[m_idx] = 0;
    end
  endtask

  task automatic ref_eval(input int n, input int p[ML], output bit ok, output int balls);
    bit landed[ML];
    int s, sum;
    ok = 1; sum = 0;
    foreach (landed[i]) landed[i] = 0;
    for (int i = 0; i < n; i++) begin
      s = (i + p[i]) % n;
      if (landed[s]) ok = 0;
      landed[s] = 1;
      sum += p[i];
    end
    balls = sum / n;
  endtask

  task automatic chk_committed();
    logic [ML-1:0][TW-1:0] ep;
    for (int i = 0; i < ML; i++) ep[i] = TW'(c_pat[i]);
    chk("pattern_out", pattern_out, ep);
    chk("length_out", length_out, c_len);
    chk("num_balls_out", num_balls_out, c_balls);
    chk("pattern_valid_out", pattern_valid_out, c_valid);
  endtask

  // Final beat of an entry (m_idx == n-1), then wait for the verdict and restart.
  task automatic finish_entry(input int n, input int p[ML], input bit burst);
    bit ok;
    int balls, cnt;
    ref_eval(n, p, ok, balls);
    throw_in = TW'(p[n-1]); new_beat = 1; tick(); new_beat = 0;
    cnt = 1;
    while (pattern_load_out !== 1'b1 && error_out !== 1'b1 && cnt < 100) begin
      tick(); cnt++;
    end
    if (ok) begin
      chk("load_seen", pattern_load_out, 1);
      chk("error_quiet", error_out, 0);
      chk("latency", cnt, 1 + n + balls + 1);
      for (int i = 0; i < ML; i++) c_pat[i] = (i < n) ? p[i] : 0;
      c_len = n; c_balls = balls; c_valid = 1;
    end else begin
      chk("error_seen", error_out, 1);
      chk("load_quiet", pattern_load_out, 0);
    end
    chk_committed();
    if (burst) begin
      repeat (ND * RC) begin
        disp_chk(ok ? 1 : 2); tick();
      end
    end else begin
      disp_chk(ok ? 1 : 2); tick();
    end
    chk("strobe_width", {pattern_load_out, error_out}, 0);
    throw_in = TW'($urandom_range(0, 15)); new_beat = 1; tick(); new_beat = 0;
    foreach (m_buf[i]) m_buf[i] = 0;
    m_idx = 0;
  endtask

  task automatic run_entry(input int n, input int p[ML], input bit burst);
    pattern_length = LW'(n);
    for (int i = 0; i < n - 1; i++) beat_in(p[i]);
    throw_in = TW'(p[n-1]); #1;
    disp_chk(0);
    finish_entry(n, p, burst);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    int p[ML];
    int n, t, mx;
    bit seen;
    foreach (m_buf[i]) begin m_buf[i] = 0; c_pat[i] = 0; end
    rst_in = 1; new_beat = 0; undo_in = 0; throw_in = 0; pattern_length = 0;
    repeat (3) tick();
    rst_in = 0;
    chk_committed();
    chk("reset_load", pattern_load_out, 0);
    chk("reset_error", error_out, 0);
    chk("reset_an", an_out, 8'hFE);
    disp_chk(0);

    p = '{5, 3, 1, 0, 0, 0, 0};
    run_entry(3, p, 1);
    p = '{4, 3, 2, 0, 0, 0, 0};
    run_entry(3, p, 1);

    // Undo with a coincident beat keeps only the undo.
    pattern_length = 3;
    beat_in(4); beat_in(4); undo(1, 9);
    throw_in = 7;
    repeat (ND * RC) begin #1; disp_chk(0); tick(); end
    beat_in(1);
    p = '{4, 1, 4, 0, 0, 0, 0};
    finish_entry(3, p, 0);

    p = '{0, 0, 0, 0, 0, 0, 0};
    run_entry(1, p, 1);

    pattern_length = 0;
    seen = 0;
    repeat (3) begin beat_in(5); seen |= pattern_load_out | error_out; end
    repeat (ND) begin #1; disp_chk(0); tick(); end
    chk("len0_no_strobe", seen, 0);
    p = '{2, 0, 0, 0, 0, 0, 0};
    run_entry(1, p, 0);

    // Reset in the middle of dividing a 7-throw entry.
    pattern_length = 7;
    repeat (6) beat_in(7);
    throw_in = 7; new_beat = 1; tick(); new_beat = 0;
    seen = 0;
    repeat (9) begin tick(); seen |= pattern_load_out | error_out; end
    rst_in = 1; tick(); tick(); rst_in = 0;
    foreach (m_buf[i]) begin m_buf[i] = 0; c_pat[i] = 0; end
    m_idx = 0; c_len = 0; c_balls = 0; c_valid = 0;
    repeat (20) begin tick(); seen |= pattern_load_out | error_out; end
    chk("abort_no_strobe", seen, 0);
    chk_committed();
    disp_chk(0);
    p = '{3, 1, 0, 0, 0, 0, 0};
    run_entry(2, p, 0);

    // Live throw on the current digit while the anodes rotate through a wrap.
    pattern_length = 4;
    beat_in(3);
    repeat (30) begin
      throw_in = TW'($urandom_range(0, 15)); #1;
      disp_chk(0); tick();
    end
    undo(0, 0);

    repeat (25) begin
      n = $urandom_range(1, ML);
      foreach (p[i]) p[i] = 0;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) p[i] = i;
        for (int i = n - 1; i > 0; i--) begin
          int j, tmp;
          j = $urandom_range(0, i);
          tmp = p[i]; p[i] = p[j]; p[j] = tmp;
        end
        for (int i = 0; i < n; i++) begin
          t = ((p[i] - i) % n + n) % n;
          mx = (15 - t) / n;
          p[i] = t + n * $urandom_range(0, mx);
        end
      end else begin
        for (int i = 0; i < n; i++) p[i] = $urandom_range(0, 15);
      end
      run_entry(n, p, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/siteswap_pattern_entry.md
Name: siteswap_pattern_entry

Overview:
- Parametrised successor to the beat-driven pattern entry block. Captures one throw per `new_beat` into a buffer of runtime-selected length.
- Validates the entry as a siteswap using a multi-cycle checker (landing-slot collision mask plus running sum), then computes the ball count by sequential division.
- Commits only valid patterns to the downstream juggling engine, so the last good pattern keeps playing after a bad entry.
- Drives a multiplexed seven-segment display showing entry progress, the result, or "Err".

Parameters:
- MAX_LEN, 7: maximum pattern length; must be ≤ NUM_DIGITS-1.
- THROW_W, 4: bits per throw value.
- NUM_DIGITS, 8: seven-segment digits driven.
- REFRESH_CYCLES, 100000: clock cycles per display digit.
- LEN_W, $clog2(MAX_LEN+1): width of length fields.
- BALL_W, THROW_W: width of the ball count.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- new_beat, input, 1: one-cycle strobe; store the throw, or restart after a result.
- undo_in, input, 1: one-cycle strobe; remove the last stored throw.
- throw_in, input, THROW_W: live throw value from the switches.
- pattern_length, input, LEN_W: requested length; sampled on the first beat of an entry.
- pattern_out, output, [THROW_W-1:0] x [MAX_LEN-1:0]: last committed valid pattern.
- length_out, output, LEN_W: length of the committed pattern.
- num_balls_out, output, BALL_W: ball count of the committed pattern.
- pattern_valid_out, output, 1: pattern_out holds a validated pattern.
- pattern_load_out, output, 1: one-cycle strobe when a new pattern is committed.
- error_out, output, 1: one-cycle strobe when an entry fails validation.
- cat_out, output, 7: cathodes, active-low, {g,f,e,d,c,b,a}.
- an_out, output, NUM_DIGITS: anodes, active-low, one-hot.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset clears all outputs and internal state to 0, except `an_out` and `cat_out`:
  - digit select = bit 0, so `an_out` = ~1.
  - refresh counter = 0.
  - state = INPUT, index = 0, buffer = 0.
  - Reset mid-CHECK or mid-DIVIDE aborts with no commit and no error strobe.
- **INPUT state:**
  - `new_beat` with index=0 latches len = `pattern_length`. If len=0 or len>MAX_LEN, the beat is ignored.
  - Otherwise `new_beat` writes buf[index] = `throw_in` and increments index.
  - When the write fills index to len, the next state is CHECK with k=0, mask=0, sum=0.
  - `undo_in` with index>0 decrements index and clears that entry. `undo_in` with index=0 does nothing.
  - If `undo_in` and `new_beat` are asserted in the same cycle, undo wins and the beat is dropped.
- **CHECK state** (one entry per cycle, cycle k):
  - slot = (k + buf[k]) mod len, computed combinationally at full width (no truncation).
  - If mask[slot] is already set, go to RESULT with result=invalid.
  - Otherwise set mask[slot], sum += buf[k], k++.
  - After k = len-1, go to DIVIDE with rem = sum, q = 0.
  - Beats and undos are ignored in CHECK and DIVIDE.
- **DIVIDE state:**
  - Each cycle: if rem ≥ len then rem -= len and q++; else go to RESULT with result=valid and balls = q.
  - rem is always 0 at exit, since a collision-free pattern's sum is a multiple of len.
- **Transition into RESULT:**
  - Valid: `pattern_out` = buf (entries ≥ len zeroed), `length_out` = len, `num_balls_out` = q, `pattern_valid_out` = 1. `pattern_load_out` is high for exactly the first RESULT cycle.
  - Invalid: `error_out` is high for the first RESULT cycle; committed outputs are unchanged.
- **RESULT state:** `new_beat` clears buf and index and returns to INPUT; that beat is not stored.
- Throw 0 is legal.
- **Latency:** from the final storing beat to the commit strobe is 1 + len + (q+1) cycles.
- **Display:**
  - The refresh counter counts to REFRESH_CYCLES-1, then the digit select rotates left (MSB wraps to bit 0).
  - Digit for anode bit NUM_DIGITS-1-d shows entry d, hex-decoded from the low 4 bits.
  - INPUT: entries d<index show buf[d]; d=index shows live `throw_in` if index<len; all other digits blank. If len is not yet latched, use `pattern_length` for the blanking bound.
  - RESULT valid: entries d<len, plus ball count on anode bit 0.
  - RESULT invalid: anode bits 2,1,0 show E, r, r (1111001, 1010000, 1010000); all others blank.
  - CHECK/DIVIDE: same as RESULT valid without the ball count.

Test Plan:
- len=3, beats 5,3,1 → CHECK 3 cycles, DIVIDE; `pattern_load_out` fires 8 cycles after the last beat; `num_balls_out`=3, `pattern_out`={5,3,1}, `length_out`=3.
- After the valid 531, enter len=3, beats 4,3,2 → collision at k=1; `error_out` pulses once; `pattern_out` stays {5,3,1}; display shows "Err".
- len=3, beats 4,4, undo, 1, 4 → buffer {4,1,4}; valid with 3 balls (sum 9/3); `undo_in`+`new_beat` same cycle → undo only.
- len=1, beat 0 → valid, `num_balls_out`=0; `pattern_length`=0 → beats ignored, index stays 0.
- `rst_in` asserted during DIVIDE of len=7 entry 7,7,7,7,7,7,7 → no strobes; all outputs 0; state INPUT.
- REFRESH_CYCLES=3 → `an_out` digit changes every 3 cycles and wraps from bit 7 to bit 0; the digit at index shows live `throw_in` as it changes.
